// File: rtl/alu_exec_unit.sv
// ALU execute unit: decodes the ALU operation, completes single-cycle ops at the accept edge,
// and runs MUL as a radix-2 shift-add over WIDTH cycles.
//
//   state   | meaning
//   IDLE    | ready to accept; non-MUL ops complete on the accept edge
//   MUL     | shift-add multiply iterating, one multiplier bit per cycle
module alu_exec_unit #(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       ALUOp,
  input  logic [10:0]      OpCode,
  input  logic [5:0]       shamt,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       code,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_ORR  = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_PASS = 4'b0111;
  localparam logic [3:0] C_MUL  = 4'b1000;
  localparam logic [3:0] C_LSL  = 4'b1010;
  localparam logic [3:0] C_LSR  = 4'b1011;
  localparam logic [3:0] C_ILL  = 4'b1111;

  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  state_t           state_q, state_d;
  logic             accept;
  logic             mul_last;
  logic [3:0]       dec_code;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic [WIDTH:0]   sum_w, diff_w;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] acc_q, mcand_q, mplier_q, acc_nxt;
  logic [CW-1:0]    cnt_q;
  logic             unused_shamt;

  assign busy     = (state_q == ST_MUL);
  assign accept   = start & ~busy;
  assign mul_last = busy & ~flush & (cnt_q == '0);
  assign sh       = shamt[SHW-1:0];
  assign unused_shamt = ^shamt;

  always_comb begin
    dec_code = C_ILL;
    case (ALUOp)
      2'b00: dec_code = C_ADD;
      2'b01: dec_code = C_PASS;
      2'b10: begin
        case (OpCode)
          11'b10001011000: dec_code = C_ADD;
          11'b11001011000: dec_code = C_SUB;
          11'b10001010000: dec_code = C_AND;
          11'b10101010000: dec_code = C_ORR;
          11'b10011011000: dec_code = C_MUL;
          11'b11010011011: dec_code = C_LSL;
          11'b11010011010: dec_code = C_LSR;
          default:         dec_code = C_ILL;
        endcase
      end
      default: dec_code = C_ILL;
    endcase
  end

  // SUB as A + ~B + 1 so the top bit is the no-borrow carry
  assign sum_w  = {1'b0, A} + {1'b0, B};
  assign diff_w = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (dec_code)
      C_ADD: begin
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (sum_w[WIDTH-1] != A[WIDTH-1]);
      end
      C_SUB: begin
        alu_res = diff_w[WIDTH-1:0];
        alu_c   = diff_w[WIDTH];
        alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (diff_w[WIDTH-1] != A[WIDTH-1]);
      end
      C_AND:   alu_res = A & B;
      C_ORR:   alu_res = A | B;
      C_PASS:  alu_res = B;
      C_LSL:   alu_res = A << sh;
      C_LSR:   alu_res = A >> sh;
      default: alu_res = '0;
    endcase
  end

  assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && (dec_code == C_MUL)) state_d = ST_MUL;
      ST_MUL:  if (flush || (cnt_q == '0)) state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done     <= 1'b0;
      result   <= '0;
      code     <= 4'b0000;
      zero     <= 1'b0;
      neg      <= 1'b0;
      carry    <= 1'b0;
      ovf      <= 1'b0;
      err      <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        code <= dec_code;
        if (dec_code == C_MUL) begin
          cnt_q    <= CW'(WIDTH - 1);
          acc_q    <= '0;
          mcand_q  <= A;
          mplier_q <= B;
        end else begin
          done   <= 1'b1;
          result <= alu_res;
          zero   <= (dec_code != C_ILL) && (alu_res == '0);
          neg    <= alu_res[WIDTH-1];
          carry  <= alu_c;
          ovf    <= alu_v;
          err    <= (dec_code == C_ILL);
        end
      end else if (busy && !flush) begin
        acc_q    <= acc_nxt;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q - 1'b1;
        if (mul_last) begin
          done   <= 1'b1;
          result <= acc_nxt;
          zero   <= (acc_nxt == '0);
          neg    <= acc_nxt[WIDTH-1];
          carry  <= 1'b0;
          ovf    <= 1'b0;
          err    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: a 64-bit and an 8-bit instance checked against an
// arithmetic reference model with directed corner cases and random operations.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start8, flush;
  logic [1:0]  aluop;
  logic [10:0] opcode;
  logic [5:0]  shamt;
  logic [63:0] a, b;
  logic [7:0]  a8, b8;

  logic        busy, done, zero, neg, carry, ovf, err;
  logic [63:0] result;
  logic [3:0]  code;
  logic        busy8, done8, zero8, neg8, carry8, ovf8, err8;
  logic [7:0]  result8;
  logic [3:0]  code8;

  int n_chk = 0;
  int n_bad = 0;

  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;
  localparam logic [10:0] OP_MUL = 11'b10011011000;
  localparam logic [10:0] OP_LSL = 11'b11010011011;
  localparam logic [10:0] OP_LSR = 11'b11010011010;

  assign a8 = a[7:0];
  assign b8 = b[7:0];

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .start(start), .ALUOp(aluop), .OpCode(opcode), .shamt(shamt),
    .A(a), .B(b), .flush(flush), .busy(busy), .done(done), .result(result), .code(code),
    .zero(zero), .neg(neg), .carry(carry), .ovf(ovf), .err(err)
  );

  alu_exec_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .ALUOp(aluop), .OpCode(opcode), .shamt(shamt),
    .A(a8), .B(b8), .flush(flush), .busy(busy8), .done(done8), .result(result8), .code(code8),
    .zero(zero8), .neg(neg8), .carry(carry8), .ovf(ovf8), .err(err8)
  );

  typedef struct packed {
    logic [63:0] res;
    logic [3:0]  code;
    logic        z, n, c, v, e;
  } exp_t;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: arithmetic on wide integers, result taken modulo 2**w
  function automatic exp_t ref_model(input int w, input logic [1:0] op, input logic [10:0] opc,
                                     input logic [5:0] sh, input logic [63:0] x, input logic [63:0] y);
    exp_t r;
    logic [127:0] mask, ux, uy, full;
    logic signed [127:0] sx, sy, s, smax, smin;
    int amt;
    r    = '0;
    full = '0;
    s    = '0;
    mask = (128'd1 << w) - 128'd1;
    ux   = {64'd0, x} & mask;
    uy   = {64'd0, y} & mask;
    sx   = ux[w-1] ? $signed(ux - (128'd1 << w)) : $signed(ux);
    sy   = uy[w-1] ? $signed(uy - (128'd1 << w)) : $signed(uy);
    smax = $signed((128'd1 << (w - 1)) - 128'd1);
    smin = -smax - 128'sd1;
    amt  = int'(sh) % w;
    if (op == 2'b00) r.code = 4'b0010;
    else if (op == 2'b01) r.code = 4'b0111;
    else if (op == 2'b10) begin
      case (opc)
        OP_ADD:  r.code = 4'b0010;
        OP_SUB:  r.code = 4'b0110;
        OP_AND:  r.code = 4'b0000;
        OP_ORR:  r.code = 4'b0001;
        OP_MUL:  r.code = 4'b1000;
        OP_LSL:  r.code = 4'b1010;
        OP_LSR:  r.code = 4'b1011;
        default: r.code = 4'b1111;
      endcase
    end else r.code = 4'b1111;
    case (r.code)
      4'b0010: begin full = ux + uy; s = sx + sy; r.c = full[w]; r.v = (s > smax) || (s < smin); end
      4'b0110: begin full = (ux - uy) & mask; s = sx - sy; r.c = (ux >= uy); r.v = (s > smax) || (s < smin); end
      4'b0000: full = ux & uy;
      4'b0001: full = ux | uy;
      4'b0111: full = uy;
      4'b1000: full = ux * uy;
      4'b1010: full = ux << amt;
      4'b1011: full = ux >> amt;
      default: full = '0;
    endcase
    r.res = 64'(full & mask);
    if (r.code == 4'b1111) r.e = 1'b1;
    else begin
      r.z = (r.res == 64'd0);
      r.n = r.res[w-1];
    end
    return r;
  endfunction

  task automatic check_out(input string tag, input exp_t e, input bit is8);
    if (is8) begin
      chk({tag, ".done"},  64'(done8),   64'd1);
      chk({tag, ".res"},   64'(result8), e.res);
      chk({tag, ".code"},  64'(code8),   64'(e.code));
      chk({tag, ".flags"}, 64'({zero8, neg8, carry8, ovf8, err8}), 64'({e.z, e.n, e.c, e.v, e.e}));
    end else begin
      chk({tag, ".done"},  64'(done),   64'd1);
      chk({tag, ".res"},   result,      e.res);
      chk({tag, ".code"},  64'(code),   64'(e.code));
      chk({tag, ".flags"}, 64'({zero, neg, carry, ovf, err}), 64'({e.z, e.n, e.c, e.v, e.e}));
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [10:0] opc, input logic [5:0] sh,
                       input logic [63:0] x, input logic [63:0] y);
    aluop = op; opcode = opc; shamt = sh; a = x; b = y;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".o64"}, 64'({busy, done, code, zero, neg, carry, ovf, err}), 64'd0);
    chk({tag, ".r64"}, result, 64'd0);
    chk({tag, ".o8"},  64'({busy8, done8, code8, zero8, neg8, carry8, ovf8, err8, result8}), 64'd0);
  endtask

  task automatic run_mul(input logic [63:0] x, input logic [63:0] y, input bit is8);
    exp_t e;
    int n;
    int w;
    w = is8 ? 8 : 64;
    e = ref_model(w, 2'b10, OP_MUL, 6'd0, x, y);
    drive(2'b10, OP_MUL, 6'd0, x, y);
    if (is8) start8 = 1'b1; else start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      start = 1'b0; start8 = 1'b0;
      n++;
    end while (!(is8 ? done8 : done) && n < w + 5);
    chk("mul.lat", 64'(n - 1), 64'(w));
    check_out("mul", e, is8);
  endtask

  task automatic gen_op(output logic [1:0] op, output logic [10:0] opc, output logic [5:0] sh,
                        output logic [63:0] x, output logic [63:0] y);
    logic [10:0] legal [6];
    logic [63:0] corner [6];
    int r;
    legal  = '{OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_LSL, OP_LSR};
    corner = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 64'h0000_0000_0000_007F, 64'h0000_0000_0000_0080};
    r = $urandom_range(0, 9);
    op = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r == 2) ? 2'b11 : 2'b10;
    r = $urandom_range(0, 6);
    opc = (op == 2'b10 && r < 6) ? legal[r] : 11'($urandom);
    if (opc == OP_MUL) opc = 11'd0;
    sh = 6'($urandom);
    x  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : {$urandom, $urandom};
    y  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : {$urandom, $urandom};
  endtask

  initial begin
    exp_t e, e8, p64, p8;
    logic [1:0]  op;
    logic [10:0] opc;
    logic [5:0]  sh;
    logic [63:0] x, y, last_res;
    int busy_cnt, lat;
    bit got;

    rst = 1'b0; start = 1'b0; start8 = 1'b0; flush = 1'b0;
    drive(2'b00, 11'd0, 6'd0, 64'd0, 64'd0);
    #1 rst = 1'b1;
    #2 chk_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // SUB 5-5
    drive(2'b10, OP_SUB, 6'd0, 64'd5, 64'd5); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("sub55.done", 64'(done), 64'd1);
    chk("sub55.res", result, 64'd0);
    chk("sub55.zcv", 64'({zero, carry, ovf}), 64'b110);
    chk("sub55.code", 64'(code), 64'b0110);

    // signed overflow on ADD
    drive(2'b10, OP_ADD, 6'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("addovf.res", result, 64'h8000_0000_0000_0000);
    chk("addovf.ncv", 64'({neg, carry, ovf}), 64'b101);

    // illegal op followed back-to-back by load/store add
    drive(2'b11, 11'($urandom), 6'd0, 64'd5, 64'd6); start = 1'b1;
    @(negedge clk);
    chk("ill.done", 64'(done), 64'd1);
    chk("ill.err", 64'(err), 64'd1);
    chk("ill.code", 64'(code), 64'hF);
    chk("ill.res", result, 64'd0);
    drive(2'b00, 11'd0, 6'd0, 64'd3, 64'd4);
    @(negedge clk); start = 1'b0;
    chk("ldst.done", 64'(done), 64'd1);
    chk("ldst.res", result, 64'd7);
    chk("ldst.err", 64'(err), 64'd0);

    // 8-bit LSL uses only low shamt bits
    drive(2'b10, OP_LSL, 6'b001001, 64'h81, 64'd0); start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    chk("lsl8.done", 64'(done8), 64'd1);
    chk("lsl8.res", 64'(result8), 64'h02);
    chk("lsl8.cz", 64'({carry8, zero8}), 64'b00);

    // MUL 7*9 with ignored starts while busy, then start in the done cycle
    drive(2'b10, OP_MUL, 6'd0, 64'd7, 64'd9); start = 1'b1;
    busy_cnt = 0; lat = 0; got = 1'b0;
    for (int n = 1; n <= 64 + 4; n++) begin
      @(negedge clk);
      if (done) begin lat = n - 1; got = 1'b1; break; end
      if (busy) busy_cnt++;
      start = (n == 5 || n == 20 || n == 40 || n == 63) ? 1'b1 : 1'b0;
      if (start) drive(2'b10, OP_ADD, 6'd0, 64'd1, 64'd1);
    end
    start = 1'b0;
    chk("mul79.seen", 64'(got), 64'd1);
    chk("mul79.lat", 64'(lat), 64'd64);
    chk("mul79.busy", 64'(busy_cnt), 64'd64);
    chk("mul79.res", result, 64'd63);
    chk("mul79.code", 64'(code), 64'b1000);
    drive(2'b10, OP_ADD, 6'd0, 64'd3, 64'd4); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("afterdone.done", 64'(done), 64'd1);
    chk("afterdone.res", result, 64'd7);
    last_res = 64'd7;

    // flush mid-multiply
    drive(2'b10, OP_MUL, 6'd0, 64'd123, 64'd456); start = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk); start = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk("flush.busy", 64'(busy), 64'd0);
    chk("flush.done", 64'(done), 64'd0);
    chk("flush.res", result, last_res);
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (done) chk("flush.stray_done", 64'(done), 64'd0);
    end
    drive(2'b10, OP_ADD, 6'd0, 64'd10, 64'd11); start = 1'b1; flush = 1'b1;
    @(negedge clk); start = 1'b0; flush = 1'b0;
    chk("flushstart.done", 64'(done), 64'd1);
    chk("flushstart.res", result, 64'd21);

    // async reset mid-multiply
    drive(2'b10, OP_MUL, 6'd0, 64'd99, 64'd77); start = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk); start = 1'b0;
    end
    #2 rst = 1'b1;
    #1 chk_reset_outputs("midreset");
    @(negedge clk);
    rst = 1'b0;
    drive(2'b00, 11'd0, 6'd0, 64'd10, 64'd20); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("postrst.done", 64'(done), 64'd1);
    chk("postrst.res", result, 64'd30);
    @(negedge clk);
    chk("postrst.pulse", 64'(done), 64'd0);

    // random back-to-back single-cycle ops on both widths
    p64 = '0; p8 = '0;
    for (int i = 0; i <= 300; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check_out("rnd64", p64, 1'b0);
        check_out("rnd8", p8, 1'b1);
      end
      if (i < 300) begin
        gen_op(op, opc, sh, x, y);
        drive(op, opc, sh, x, y);
        start = 1'b1; start8 = 1'b1;
        p64 = ref_model(64, op, opc, sh, x, y);
        p8  = ref_model(8, op, opc, sh, x, y);
      end else begin
        start = 1'b0; start8 = 1'b0;
      end
    end

    // random multiplies
    for (int i = 0; i < 8; i++) run_mul({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    run_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    for (int i = 0; i < 8; i++) run_mul(64'($urandom), 64'($urandom), 1'b1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
